// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//   Wide add/subtract built from a single 4-bit ripple adder (Adder4bit).
//   Operands are processed one nibble per clock, least-significant nibble
//   first, with the carry registered between nibbles.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   Start    : operation request, sampled only while idle
//   Sub      : 0 = A + B + Cin, 1 = A - B (captured with Start)
//   Cin      : carry-in for add, ignored for subtract
//   A, B     : WIDTH-bit operands (captured with Start)
//   Busy     : high while an operation is running or completing
//   Done     : one-cycle pulse, results valid
//   Sum      : registered WIDTH-bit result
//   Cout     : final carry out (subtract: 1 = no borrow)
//   Overflow : signed two's-complement overflow
// -----------------------------------------------------------------------------

// 4-bit ripple-carry adder: the only arithmetic datapath of the block.
module Adder4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  always_comb begin
    c[0] = ci;
    for (int unsigned i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;     // already inverted for subtract
  logic             carry;
  logic [IW-1:0]    idx;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_nib;
  logic             c_nib;

  // Nibble selection by index.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  Adder4bit u_add (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry),
    .s  (s_nib),
    .co (c_nib)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state    <= S_RUN;
            a_q      <= A;
            b_q      <= Sub ? ~B : B;
            // Subtract is A + ~B + 1.
            carry    <= Sub ? 1'b1 : Cin;
            idx      <= '0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
          end
        end
        S_RUN: begin
          for (int unsigned i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
              Sum[4*i +: 4] <= s_nib;
            end
          end
          carry <= c_nib;
          if (idx == LAST) begin
            state    <= S_DONE;
            idx      <= '0;
            Cout     <= c_nib;
            // Same-sign operands producing a different-sign result.
            Overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (s_nib[3] != a_q[WIDTH-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy = (state == S_RUN) || (state == S_DONE);
  assign Done = (state == S_DONE);

endmodule
